// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the data-memory access controller.
// Carries both requester ports (valid/we/addr/be/wdata in, ready out),
// the per-port response pulses with the shared response data/error, and the
// single-port memory side (addr/wdata/rw out, combinational rdata in).
//   master : requesters plus the memory model (drives requests and mem_rdata)
//   slave  : the controller itself
interface dmem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [3:0]        req0_be;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [3:0]        req1_be;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
        input  req0_ready,
        output req1_valid, req1_we, req1_addr, req1_be, req1_wdata,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_rw,
        output mem_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
        output req0_ready,
        input  req1_valid, req1_we, req1_addr, req1_be, req1_wdata,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_rw,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates two requesters (port 0 CPU,
// port 1 debug/loader) onto one single-port word memory, one operation in
// flight. Partial stores are done as read-modify-write.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (also blanks all outputs while high)
//   bus  dmem_access_ctrl_if slave: request ports, response pulses, memory side
//
// state | meaning
// IDLE  | waiting; grants one valid request and latches it
// RD    | memory read of the target word (loads, partial stores)
// WR    | single-cycle memory write of full or merged word
// RESP  | one-cycle response pulse to the latched port
module dmem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WORD_ADDR_W = 3,
    parameter int RR_EN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   cmd_we, cmd_err, cmd_port, last_grant;
    logic [WORD_ADDR_W-1:0] cmd_idx;
    logic [3:0]             cmd_be;
    logic [DATA_W-1:0]      cmd_wdata;
    logic [DATA_W-1:0]      word_q;

    logic                   any_valid, grant_sel, accept;
    logic                   sel_we, sel_err;
    logic [ADDR_W-1:0]      sel_addr;
    logic [3:0]             sel_be;
    logic [DATA_W-1:0]      sel_wdata;
    logic [DATA_W-1:0]      merged;

    logic                   ready0, ready1, rsp0, rsp1, rsp_err_c, mem_rw_c;
    logic [DATA_W-1:0]      rsp_rdata_c, mem_wdata_c;
    logic [31:0]            mem_addr_c;
    logic                   unused_addr_lsbs;

    assign any_valid = bus.req0_valid | bus.req1_valid;

    // Tie goes to the port that did not win last time; a lone request always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            grant_sel = (RR_EN != 0) ? ~last_grant : 1'b0;
        else
            grant_sel = bus.req1_valid;
    end

    assign sel_we    = grant_sel ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant_sel ? bus.req1_addr  : bus.req0_addr;
    assign sel_be    = grant_sel ? bus.req1_be    : bus.req0_be;
    assign sel_wdata = grant_sel ? bus.req1_wdata : bus.req0_wdata;
    assign sel_err   = |sel_addr[ADDR_W-1:WORD_ADDR_W+2];

    // Byte address lanes select nothing in a word memory.
    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_comb begin
        merged = '0;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = cmd_be[k] ? cmd_wdata[8*k +: 8] : bus.mem_rdata[8*k +: 8];
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        rsp0        = 1'b0;
        rsp1        = 1'b0;
        rsp_rdata_c = '0;
        rsp_err_c   = 1'b0;
        mem_rw_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    accept = 1'b1;
                    if (sel_err || (sel_we && sel_be == 4'h0))
                        state_d = RESP;
                    else if (!sel_we || sel_be != 4'hF)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD: begin
                mem_addr_c = 32'(cmd_idx);
                state_d    = cmd_we ? WR : RESP;
            end
            WR: begin
                mem_rw_c    = 1'b1;
                mem_addr_c  = 32'(cmd_idx);
                mem_wdata_c = word_q;
                state_d     = RESP;
            end
            RESP: begin
                rsp0        = ~cmd_port;
                rsp1        = cmd_port;
                rsp_rdata_c = (!cmd_we && !cmd_err) ? word_q : '0;
                rsp_err_c   = cmd_err;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset blanks everything in the same cycle, including a write in progress.
        if (rst) begin
            accept      = 1'b0;
            rsp0        = 1'b0;
            rsp1        = 1'b0;
            rsp_rdata_c = '0;
            rsp_err_c   = 1'b0;
            mem_rw_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end
    end

    assign ready0 = accept & ~grant_sel;
    assign ready1 = accept & grant_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_port   <= 1'b0;
            cmd_idx    <= '0;
            cmd_be     <= '0;
            cmd_wdata  <= '0;
            word_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_we     <= sel_we;
                cmd_err    <= sel_err;
                cmd_port   <= grant_sel;
                cmd_idx    <= sel_addr[WORD_ADDR_W+1:2];
                cmd_be     <= sel_be;
                cmd_wdata  <= sel_wdata;
                last_grant <= grant_sel;
                // Full stores go straight to WR with this word.
                word_q     <= sel_wdata;
            end else if (state_q == RD) begin
                word_q <= cmd_we ? merged : bus.mem_rdata;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0;
    assign bus.rsp1_valid = rsp1;
    assign bus.rsp_rdata  = rsp_rdata_c;
    assign bus.rsp_err    = rsp_err_c;
    assign bus.mem_rw     = mem_rw_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule
